hex_fragment_writer: RTL and testbench
======================================

Name: hex_fragment_writer

Overview:
- Downstream consumer of the hexagonal rasterizer's output stream.
- Accepts axial hex fragments (q, r, colour) through a ready/valid handshake and buffers them in a small FIFO.
- Converts each fragment to an odd-r offset framebuffer address, clips anything outside the grid, and writes in-bounds fragments to the hex framebuffer memory through a req/ack port.
- Also performs a full framebuffer clear on request.

Parameters:
- COORD_W, 32: width of the signed axial q/r inputs (integer hex coordinates).
- COLOR_W, 16: fragment colour / memory data width.
- GRID_W, 64: framebuffer columns.
- GRID_H, 64: framebuffer rows.
- ADDR_W, 12: memory address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H.
- FIFO_DEPTH, 8: fragment FIFO entries; power of two, at least 2.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- frag_valid, input, 1: fragment present.
- frag_ready, output, 1: FIFO can accept a fragment.
- frag_q, input, COORD_W: signed axial q.
- frag_r, input, COORD_W: signed axial r.
- frag_color, input, COLOR_W: fragment colour.
- clear, input, 1: single-cycle pulse requesting a framebuffer clear.
- mem_req, output, 1: write request.
- mem_addr, output, ADDR_W: write address.
- mem_data, output, COLOR_W: write data.
- mem_ack, input, 1: memory accepted the write (sampled on a rising edge).
- busy, output, 1: work pending or in progress.
- wr_count, output, 16: fragment writes completed.
- drop_count, output, 16: fragments clipped.

Behaviour:
- Reset (reset==0, asynchronous):
  - mem_req=0, mem_addr=0, mem_data=0, wr_count=0, drop_count=0, busy=0.
  - FIFO emptied, clear_pending=0, FSM=IDLE.
  - frag_ready=1 once reset is released.
  - Any in-flight write is abandoned, and mem_req falls without waiting for a clock edge.
- Input handshake:
  - A transfer occurs on a rising edge when frag_valid && frag_ready.
  - frag_ready = !fifo_full; it is registered-state based and has no combinational path from frag_valid.
  - Push and pop in the same cycle are legal whenever the FIFO is not full.
- Address mapping (signed arithmetic, intermediates COORD_W+1 bits wide):
  - row = r.
  - col = q + ((r - (r & 1)) >>> 1), using an arithmetic shift (for example, r=-1 gives an offset of -1).
  - A fragment is in-bounds iff 0 <= col < GRID_W and 0 <= row < GRID_H.
  - addr = row*GRID_W + col, truncated to ADDR_W.
- FSM states:
  - IDLE:
    - If clear_pending, go to CLEAR with clr_addr=0. Clear has priority over the FIFO.
    - Otherwise, if the FIFO is non-empty, pop one entry, register col/row/colour and go to CHECK.
  - CHECK:
    - In-bounds: load mem_addr/mem_data, set mem_req=1, go to WRITE.
    - Out-of-bounds: drop_count += 1 (saturating at 0xFFFF), go to IDLE. No memory access occurs.
  - WRITE:
    - Hold mem_req, mem_addr and mem_data stable until an edge samples mem_ack=1.
    - On that edge: mem_req=0, wr_count += 1 (saturating), go to IDLE.
    - mem_ack while mem_req=0 is ignored.
  - CLEAR:
    - Issue one write per address with data 0, addresses 0 .. GRID_W*GRID_H-1 ascending. Each write uses the same req/ack rules as WRITE, and mem_req is deasserted for one cycle between writes.
    - After the ack for the last address, clear_pending=0 and go to IDLE.
    - Clear writes do not change wr_count.
- Clear requests:
  - A clear pulse in any state sets clear_pending. A pulse arriving while already pending or clearing is absorbed, giving a single clear.
  - A clear arriving in WRITE is serviced only after the current ack.
  - The FIFO keeps accepting fragments during CLEAR.
- Latency: a fragment accepted at edge E with the FSM in IDLE and the FIFO empty pops at E+1 and shows mem_req=1 after E+2. Minimum throughput is one fragment per 3 cycles with mem_ack tied high.
- busy = (state != IDLE) || !fifo_empty || clear_pending.

Test Plan:
1. Reset:
   - Stimulus: assert reset=0 with random inputs, then release.
   - Required: mem_req=0, busy=0, wr_count=0, drop_count=0; frag_ready=1 after release.
2. Single write:
   - Stimulus: q=3, r=2, colour=0xABCD; mem_ack raised 3 cycles after mem_req.
   - Required: mem_req rises 2 cycles after acceptance with mem_addr=132 (col 4, row 2) and mem_data=0xABCD, held stable until ack; after ack, wr_count=1 and busy=0.
3. Odd row and clipping:
   - Stimulus: (q=-1, r=3), then (q=-2, r=3), then (q=0, r=64).
   - Required: first fragment writes addr 192; second (col -1) and third (row 64) produce no mem_req; drop_count=2.
4. Back-pressure:
   - Stimulus: mem_ack held 0; frag_valid held 1 with 10 distinct fragments.
   - Required: 9 accepted (1 in WRITE, 8 in FIFO), then frag_ready=0. When ack is released, all 9 are written in order and frag_ready returns to 1.
5. Clear during write:
   - Stimulus: clear pulse while in WRITE; a second clear pulse mid-clear.
   - Required: the pending write completes first; exactly 4096 zero writes to addresses 0..4095 follow; wr_count is unchanged by the clear; buffered fragments then write normally.
6. Reset mid-operation:
   - Stimulus: drive reset=0 between edges while in WRITE with 3 fragments queued.
   - Required: mem_req=0 immediately; FIFO empty and counters 0 after release; the abandoned fragment is never written.

Source files
------------

// File: rtl/hex_fragment_writer.sv
// Buffers axial hex fragments, maps them to odd-r offset framebuffer addresses,
// clips out-of-grid fragments and writes the rest (or a full clear) over req/ack.
module hex_fragment_writer #(
  parameter int COORD_W    = 32,
  parameter int COLOR_W    = 16,
  parameter int GRID_W     = 64,
  parameter int GRID_H     = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frag_valid,
  output logic                      frag_ready,
  input  logic signed [COORD_W-1:0] frag_q,
  input  logic signed [COORD_W-1:0] frag_r,
  input  logic        [COLOR_W-1:0] frag_color,
  input  logic                      clear,
  output logic                      mem_req,
  output logic        [ADDR_W-1:0]  mem_addr,
  output logic        [COLOR_W-1:0] mem_data,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic        [15:0]        wr_count,
  output logic        [15:0]        drop_count
);

  // state | meaning
  // IDLE  | waiting; clear request beats queued fragments
  // CHECK | popped fragment registered, bounds test
  // WRITE | fragment write outstanding until mem_ack
  // CLEAR | zero-fill 0..GRID_W*GRID_H-1, req low one cycle between writes
  typedef enum logic [1:0] {IDLE, CHECK, WRITE, CLEAR} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2 * COORD_W + COLOR_W;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [COORD_W:0]   GRID_W_C  = (COORD_W + 1)'(GRID_W);
  localparam logic [COORD_W:0]   GRID_H_C  = (COORD_W + 1)'(GRID_H);

  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full, push, pop;

  state_t                     state_q, state_d;
  logic signed [COORD_W:0]    col_q, col_d, row_q, row_d;
  logic        [COLOR_W-1:0]  color_q, color_d;
  logic                       mem_req_q, mem_req_d;
  logic        [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic        [COLOR_W-1:0]  mem_data_q, mem_data_d;
  logic        [15:0]         wr_count_q, wr_count_d, drop_count_q, drop_count_d;
  logic                       clear_pending_q, clear_pending_d;
  logic        [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

  logic signed [COORD_W-1:0]  head_q, head_r;
  logic        [COLOR_W-1:0]  head_color;
  logic signed [COORD_W:0]    q_ext, r_ext, r_even, head_col;
  logic                       in_bounds;
  logic        [ADDR_W-1:0]   flat_addr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign frag_ready = !fifo_full;
  assign push       = frag_valid && !fifo_full;

  assign {head_q, head_r, head_color} = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  // Odd-r offset: rounding r down to even before the arithmetic halving
  assign q_ext    = {head_q[COORD_W-1], head_q};
  assign r_ext    = {head_r[COORD_W-1], head_r};
  assign r_even   = r_ext - {{COORD_W{1'b0}}, head_r[0]};
  assign head_col = q_ext + (r_even >>> 1);

  assign in_bounds = !col_q[COORD_W] && (col_q < GRID_W_C) &&
                     !row_q[COORD_W] && (row_q < GRID_H_C);
  assign flat_addr = row_q[ADDR_W-1:0] * ADDR_W'(GRID_W) + col_q[ADDR_W-1:0];

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    row_d           = row_q;
    color_d         = color_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    mem_data_d      = mem_data_q;
    wr_count_d      = wr_count_q;
    drop_count_d    = drop_count_q;
    clr_addr_d      = clr_addr_q;
    clear_pending_d = clear_pending_q || clear;
    pop             = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_pending_q) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = '0;
          mem_data_d = '0;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          col_d   = head_col;
          row_d   = r_ext;
          color_d = head_color;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (in_bounds) begin
          mem_req_d  = 1'b1;
          mem_addr_d = flat_addr;
          mem_data_d = color_q;
          state_d    = WRITE;
        end else begin
          if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            if (clr_addr_q == LAST_ADDR) begin
              clear_pending_d = 1'b0;
              state_d         = IDLE;
            end else begin
              clr_addr_d = clr_addr_q + 1'b1;
            end
          end
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = clr_addr_q;
          mem_data_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {frag_q, frag_r, frag_color};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      col_q           <= '0;
      row_q           <= '0;
      color_q         <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      wr_count_q      <= '0;
      drop_count_q    <= '0;
      clear_pending_q <= 1'b0;
      clr_addr_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      row_q           <= row_d;
      color_q         <= color_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      wr_count_q      <= wr_count_d;
      drop_count_q    <= drop_count_d;
      clear_pending_q <= clear_pending_d;
      clr_addr_q      <= clr_addr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
  assign busy       = (state_q != IDLE) || !fifo_empty || clear_pending_q;

endmodule

// File: tb/tb_hex_fragment_writer.sv
// Bench for hex_fragment_writer: directed scenarios plus random fragments,
// checked against an arithmetic hex-to-offset reference model and a memory responder.
module tb_hex_fragment_writer;

  logic               clk = 1'b0;
  logic               reset;
  logic               frag_valid, frag_ready, clear;
  logic signed [31:0] frag_q, frag_r;
  logic        [15:0] frag_color, mem_data, wr_count, drop_count;
  logic        [11:0] mem_addr;
  logic               mem_req, mem_ack, busy;

  int n_checks = 0, n_errors = 0;
  int model_wr = 0, model_drop = 0, clr_left = 0, stray = 0;
  int ack_lat = -1;
  bit ack_en = 1'b1, ack_noise = 1'b0, clear_after = 1'b0;
  int exp_addr[$], exp_data[$];

  bit          req_seen = 1'b0;
  int          lat_cnt = 0;
  logic [11:0] held_addr;
  logic [15:0] held_data;

  hex_fragment_writer dut (
    .clk(clk), .reset(reset), .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_q(frag_q), .frag_r(frag_r), .frag_color(frag_color), .clear(clear),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .busy(busy), .wr_count(wr_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: row = r, col = q + floor(r/2); flat address row*64 + col.
  task automatic model_accept(input int q, input int r, input int c);
    longint col, row, off;
    row = r;
    off = (row >= 0) ? row / 2 : -((-row + 1) / 2);
    col = q + off;
    if (col >= 0 && col < 64 && row >= 0 && row < 64) begin
      exp_addr.push_back(int'(row * 64 + col));
      exp_data.push_back(c & 16'hFFFF);
    end else begin
      model_drop++;
    end
  endtask

  task automatic record_write(input logic [11:0] a, input logic [15:0] d);
    if (clr_left > 0) begin
      check_val("clr_addr", a, 4096 - clr_left);
      check_val("clr_data", d, 0);
      clr_left--;
    end else if (exp_addr.size() > 0) begin
      check_val("wr_addr", a, exp_addr.pop_front());
      check_val("wr_data", d, exp_data.pop_front());
      model_wr++;
      if (clear_after) begin
        clear_after = 1'b0;
        clr_left    = 4096;
      end
    end else begin
      stray++;
    end
  endtask

  // Memory responder: acks after a latency, checks request stability, logs writes.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ack  = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        req_seen = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!req_seen) begin
          req_seen  = 1'b1;
          held_addr = mem_addr;
          held_data = mem_data;
          lat_cnt   = (ack_lat < 0) ? int'($urandom_range(0, 2)) : ack_lat;
        end else begin
          check_val("hold_addr", mem_addr, held_addr);
          check_val("hold_data", mem_data, held_data);
        end
        if (ack_en && lat_cnt == 0) begin
          mem_ack  = 1'b1;
          req_seen = 1'b0;
          record_write(mem_addr, mem_data);
        end else if (lat_cnt > 0) begin
          lat_cnt--;
        end
      end else if (req_seen) begin
        check_val("req_held", mem_req, 1);
        req_seen = 1'b0;
      end
    end
  end

  task automatic push_frag(input int q, input int r, input int c);
    bit done = 1'b0;
    frag_q     = q;
    frag_r     = r;
    frag_color = c[15:0];
    frag_valid = 1'b1;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (frag_ready) begin
        model_accept(q, r, c);
        done = 1'b1;
      end
      @(negedge clk);
    end
    frag_valid = 1'b0;
    check_val("push_accepted", done, 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_addr.size() == 0 && clr_left == 0) break;
      @(negedge clk);
    end
    check_val("idle_busy", busy, 0);
    check_val("idle_pending_writes", exp_addr.size(), 0);
    check_val("idle_clear_left", clr_left, 0);
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_wr_count"}, wr_count, model_wr);
    check_val({tag, "_drop_count"}, drop_count, model_drop);
    check_val({tag, "_stray"}, stray, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    reset = 1'b0; frag_valid = 1'b0; clear = 1'b0;
    frag_q = '0; frag_r = '0; frag_color = '0;

    // Reset with random inputs
    ack_noise = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frag_valid = 1'($urandom_range(0, 1));
      clear      = 1'($urandom_range(0, 1));
      frag_q     = $urandom;
      frag_r     = $urandom;
      frag_color = 16'($urandom);
      @(negedge clk);
      check_val("rst_mem_req", mem_req, 0);
      check_val("rst_busy", busy, 0);
    end
    check_val("rst_wr_count", wr_count, 0);
    check_val("rst_drop_count", drop_count, 0);
    frag_valid = 1'b0; clear = 1'b0; ack_noise = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rel_frag_ready", frag_ready, 1);
    check_val("rel_busy", busy, 0);
    check_val("rel_mem_req", mem_req, 0);

    // Single write with latency check
    ack_lat = 3;
    push_frag(3, 2, 'hABCD);
    check_val("lat_req_e1", mem_req, 0);
    @(negedge clk);
    check_val("lat_req_e2", mem_req, 0);
    @(negedge clk);
    check_val("lat_req_e3", mem_req, 1);
    check_val("single_addr", mem_addr, 132);
    check_val("single_data", mem_data, 'hABCD);
    wait_idle(100);
    check_val("single_wr_count", wr_count, 1);
    check_counts("single");

    // Odd row and clipping
    ack_lat = -1;
    push_frag(-1, 3, 'h1234);
    push_frag(-2, 3, 'h2345);
    push_frag(0, 64, 'h3456);
    wait_idle(100);
    check_val("clip_drop_count", drop_count, 2);
    check_counts("clip");

    // Back-pressure with ack held low
    ack_en = 1'b0;
    accepted = 0;
    frag_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      frag_q = accepted; frag_r = 5; frag_color = 16'h0100 + 16'(accepted);
      if (frag_ready) begin
        model_accept(accepted, 5, 'h100 + accepted);
        accepted++;
      end
      @(negedge clk);
    end
    check_val("bp_accepted", accepted, 9);
    check_val("bp_frag_ready", frag_ready, 0);
    ack_en = 1'b1; ack_lat = 0;
    push_frag(accepted, 5, 'h100 + accepted);
    wait_idle(200);
    check_val("bp_ready_back", frag_ready, 1);
    check_counts("bp");

    // Clear arriving during a write, second clear mid-clear
    ack_lat = 2;
    push_frag(5, 6, 'h1111);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    check_val("clr_in_write", mem_req, 1);
    clear = 1'b1; clear_after = 1'b1;
    @(negedge clk);
    clear = 1'b0; ack_lat = 0;
    for (int i = 0; i < 50 && clr_left == 0; i++) @(negedge clk);
    check_val("clr_started", clr_left > 0, 1);
    push_frag(10, 20, 'h2222);
    push_frag(-3, 7, 'h3333);
    push_frag(1, 63, 'h4444);
    for (int i = 0; i < 10000 && clr_left > 2000; i++) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_idle(20000);
    check_counts("clear");

    // Random fragments against the model
    ack_lat = -1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_frag(int'($urandom_range(0, 75)) - 5, int'($urandom_range(0, 70)) - 3,
                int'($urandom_range(0, 65535)));
    end
    wait_idle(2000);
    check_counts("random");

    // Reset between edges while a write is outstanding and 3 are queued
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) push_frag(i + 1, 4, 'h5000 + i);
    repeat (5) @(negedge clk);
    check_val("mid_req_before", mem_req, 1);
    #2 reset = 1'b0;
    #1 check_val("mid_req_async", mem_req, 0);
    exp_addr.delete(); exp_data.delete();
    model_wr = 0; model_drop = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_busy", busy, 0);
    check_val("mid_frag_ready", frag_ready, 1);
    ack_en = 1'b1;
    repeat (30) @(negedge clk);
    check_val("mid_req_after", mem_req, 0);
    check_counts("mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
